// File: rtl/ft_recovery_ctrl_pkg.sv
// Shared constants and the recovery state encoding for the lockstep
// rollback controller.
package ft_pkg;

  localparam int FT_NUM_REGS     = 32;
  localparam int FT_DRAIN_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    REPLAY,
    SET_PC,
    DONE
  } ft_rec_state_e;

endpackage

// File: rtl/ft_recovery_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones
// instead of wrapping.
module ft_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign count_d = (inc_i && (count_q != '1)) ? count_q + 1'b1 : count_q;

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // a blocking = here would let later statements see the new value.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Rollback recovery sequencer: drain, replay shadow GPRs x1..x31 into both
// cores, restore PC, release fetch. Back-to-back recoveries chain via pending.
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = FT_NUM_REGS,
  parameter int DRAIN_CYCLES = FT_DRAIN_CYCLES,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
  input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
  output logic                  sgpr_we_block_o,
  input  logic [DATA_WIDTH-1:0] spc_i,
  output logic                  core_we_o,
  output logic [ADDR_WIDTH-1:0] core_waddr_o,
  output logic [DATA_WIDTH-1:0] core_wdata_o,
  output logic                  pc_set_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  fetch_block_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  err_count_o
);

  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_W-1:0]     DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(NUM_REGS - 1);

  ft_rec_state_e         state_q;
  logic [DCNT_W-1:0]     drain_cnt_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  pending_q;
  logic                  fetch_block_q;
  logic                  sgpr_we_block_q;
  logic                  core_we_q;
  logic                  pc_set_q;
  logic                  busy_q;
  logic                  done_q;

  // An error arriving during DONE itself still chains a new recovery.
  logic restart;
  logic count_inc;
  assign restart   = pending_q | error_i;
  assign count_inc = ((state_q == IDLE) && error_i) || ((state_q == DONE) && restart);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      drain_cnt_q     <= '0;
      ptr_q           <= '0;
      pending_q       <= 1'b0;
      fetch_block_q   <= 1'b0;
      sgpr_we_block_q <= 1'b0;
      core_we_q       <= 1'b0;
      pc_set_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      core_we_q <= 1'b0;
      pc_set_q  <= 1'b0;
      done_q    <= 1'b0;
      if ((state_q != IDLE) && (state_q != DONE) && error_i) pending_q <= 1'b1;
      unique case (state_q)
        IDLE: if (error_i) begin
          state_q         <= DRAIN;
          drain_cnt_q     <= DRAIN_LOAD;
          fetch_block_q   <= 1'b1;
          sgpr_we_block_q <= 1'b1;
          busy_q          <= 1'b1;
        end
        DRAIN: if (drain_cnt_q == '0) begin
          state_q   <= REPLAY;
          ptr_q     <= ADDR_WIDTH'(1);
          core_we_q <= 1'b1;
        end else begin
          drain_cnt_q <= drain_cnt_q - 1'b1;
        end
        REPLAY: if (ptr_q == LAST_PTR) begin
          state_q  <= SET_PC;
          ptr_q    <= '0;
          pc_set_q <= 1'b1;
        end else begin
          ptr_q     <= ptr_q + 1'b1;
          core_we_q <= 1'b1;
        end
        SET_PC: begin
          state_q         <= DONE;
          done_q          <= 1'b1;
          sgpr_we_block_q <= 1'b0;
          fetch_block_q   <= restart;
        end
        DONE: begin
          pending_q <= 1'b0;
          if (restart) begin
            state_q         <= DRAIN;
            drain_cnt_q     <= DRAIN_LOAD;
            fetch_block_q   <= 1'b1;
            sgpr_we_block_q <= 1'b1;
          end else begin
            state_q       <= IDLE;
            fetch_block_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ft_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (count_inc),
    .count_o(err_count_o)
  );

  // Datapath outputs are gated by registered strobes, never by error_i.
  assign sgpr_raddr_o    = core_we_q ? ptr_q : '0;
  assign core_waddr_o    = core_we_q ? ptr_q : '0;
  assign core_wdata_o    = core_we_q ? sgpr_rdata_i : '0;
  assign core_we_o       = core_we_q;
  assign pc_set_o        = pc_set_q;
  assign pc_o            = pc_set_q ? spc_i : '0;
  assign fetch_block_o   = fetch_block_q;
  assign sgpr_we_block_o = sgpr_we_block_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
